// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding select encodings, register-zero and shared hazard helpers for hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         MD_CYCLES_DEF = 32;

    // A producer matches a consumer only if it really writes a non-zero register.
    function automatic logic reg_hit(input logic [4:0] src,
                                     input logic [4:0] dst,
                                     input logic       we);
        return we && (dst != REG_ZERO) && (dst == src);
    endfunction

    // M wins over W: it holds the younger value of the register.
    function automatic fwd_e fwd_select(input logic [4:0] src,
                                        input logic [4:0] wa_m,
                                        input logic       we_m,
                                        input logic [4:0] wa_w,
                                        input logic       we_w);
        if (reg_hit(src, wa_m, we_m)) begin
            return FWD_MEM;
        end else if (reg_hit(src, wa_w, we_w)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// rtl/hazard_ctrl_md_busy_timer.sv - loadable down-counter tracking how long mult/div still owns HI/LO
module md_busy_timer #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // A new start restarts the count even when an operation is still running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD_VAL;
        end else if (busy) begin
            cnt <= cnt - ONE;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS32 pipeline hazard/forwarding control; optional perf counters under HAZARD_PERF_EN
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  wa_e,
    input  logic [4:0]  wa_m,
    input  logic [4:0]  wa_w,
    input  logic        we_e,
    input  logic        we_m,
    input  logic        we_w,
    input  logic        memtoreg_e,
    input  logic        memtoreg_m,
    input  logic        branch_d,
    input  logic        pcsrc_d,
    input  logic        md_start_e,
    input  logic        md_use_d,
    output logic        en_f,
    output logic        en_d,
    output logic        en_e,
    output logic        en_m,
    output logic        clr_d,
    output logic        clr_e,
    output logic        fwd_a_d,
    output logic        fwd_b_d,
    output logic [1:0]  fwd_a_e,
    output logic [1:0]  fwd_b_e,
    output logic        md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_start_e),
        .busy  (md_busy)
    );

    always_comb begin
        fwd_a_e = fwd_select(rs_e, wa_m, we_m, wa_w, we_w);
        fwd_b_e = fwd_select(rt_e, wa_m, we_m, wa_w, we_w);
        fwd_a_d = reg_hit(rs_d, wa_m, we_m);
        fwd_b_d = reg_hit(rt_d, wa_m, we_m);
    end

    // Branch compare in D needs E results and M load data that cannot be forwarded yet.
    always_comb begin
        lwstall = memtoreg_e && (reg_hit(rs_d, wa_e, we_e) || reg_hit(rt_d, wa_e, we_e));
        brstall = branch_d &&
                  (reg_hit(rs_d, wa_e, we_e) || reg_hit(rt_d, wa_e, we_e) ||
                   reg_hit(rs_d, wa_m, memtoreg_m) || reg_hit(rt_d, wa_m, memtoreg_m));
        mdstall = md_use_d && (md_busy || md_start_e);
        stall   = lwstall || brstall || mdstall;
    end

    // Redirect only once the branch operands are valid, so a stall suppresses the flush.
    always_comb begin
        en_f  = !stall;
        en_d  = !stall;
        en_e  = 1'b1;
        en_m  = 1'b1;
        clr_e = stall;
        clr_d = pcsrc_d && !stall;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (stall && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (clr_d && (perf_flush != 32'hFFFF_FFFF)) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors (MD_CYCLES = 4)
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic        we_e, we_m, we_w, memtoreg_e, memtoreg_m;
    logic        branch_d, pcsrc_d, md_start_e, md_use_d;
    logic        en_f, en_d, en_e, en_m, clr_d, clr_e, fwd_a_d, fwd_b_d, md_busy;
    logic [1:0]  fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    typedef struct {
        string       name;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall_cnt = 0;
    int   exp_flush_cnt = 0;

    hazard_ctrl #(.MD_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .we_e(we_e), .we_m(we_m), .we_w(we_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .pcsrc_d(pcsrc_d),
        .md_start_e(md_start_e), .md_use_d(md_use_d),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
        .clr_d(clr_d), .clr_e(clr_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Expected output word: {en_f,en_d,en_e,en_m,clr_d,clr_e,fwd_a_d,fwd_b_d,fwd_a_e,fwd_b_e,md_busy}
    function automatic logic [12:0] ex(input logic stall, input logic cd,
                                       input logic fad, input logic fbd,
                                       input logic [1:0] fae, input logic [1:0] fbe,
                                       input logic busy);
        return {~stall, ~stall, 1'b1, 1'b1, cd, stall, fad, fbd, fae, fbe, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wa_e = 0; wa_m = 0; wa_w = 0;
        we_e = 0; we_m = 0; we_w = 0; memtoreg_e = 0; memtoreg_m = 0;
        branch_d = 0; pcsrc_d = 0; md_start_e = 0; md_use_d = 0;
    endtask

    task automatic expect_out(input string nm, input logic [12:0] e);
        exp_t item;
        item.name = nm;
        item.val  = e;
        sb.push_back(item);
        if (rst) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            if (!e[12]) exp_stall_cnt++;
            if (e[8])   exp_flush_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        item;
            logic [12:0] got;
            item = sb.pop_front();
            got  = {en_f, en_d, en_e, en_m, clr_d, clr_e, fwd_a_d, fwd_b_d,
                    fwd_a_e, fwd_b_e, md_busy};
            checks++;
            if (got !== item.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", item.name, got, item.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); rst = 1'b1;
        expect_out("reset", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); rst = 1'b0;
        expect_out("post_reset", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); memtoreg_e = 1; we_e = 1; wa_e = 8; rs_d = 8;
        expect_out("load_use_stall", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); memtoreg_m = 1; we_m = 1; wa_m = 8; rs_e = 8; rs_d = 8;
        expect_out("load_use_release_fwd", ex(0, 0, 1, 0, 2'b10, 2'b00, 0));
        tick(); memtoreg_e = 1; we_e = 1; wa_e = 0; rs_d = 0; rt_d = 0;
        expect_out("load_r0_no_stall", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); we_m = 1; wa_m = 5; we_w = 1; wa_w = 5; rs_e = 5;
        expect_out("fwd_mem_priority", ex(0, 0, 0, 0, 2'b10, 2'b00, 0));
        tick(); we_m = 0; wa_m = 5; we_w = 1; wa_w = 5; rs_e = 5;
        expect_out("fwd_wb", ex(0, 0, 0, 0, 2'b01, 2'b00, 0));
        tick(); we_m = 1; wa_m = 0; we_w = 1; wa_w = 0; rs_e = 5;
        expect_out("fwd_rf", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); we_m = 1; wa_m = 0; we_w = 1; wa_w = 0; rs_e = 0; rt_e = 0;
        expect_out("fwd_r0_never", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); we_m = 1; wa_m = 3; we_w = 1; wa_w = 9; rs_e = 9; rt_e = 3;
        expect_out("fwd_independent", ex(0, 0, 0, 0, 2'b01, 2'b10, 0));
        tick(); we_m = 1; wa_m = 7; rt_d = 7;
        expect_out("fwd_b_d", ex(0, 0, 0, 1, 2'b00, 2'b00, 0));

        tick(); branch_d = 1; pcsrc_d = 1; rs_d = 1; rt_d = 2;
        expect_out("branch_flush", ex(0, 1, 0, 0, 2'b00, 2'b00, 0));
        tick();
        expect_out("branch_flush_done", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 0; i < 2; i++) begin
            tick(); branch_d = 1; pcsrc_d = 1; rs_d = 1; rt_d = 2; we_e = 1; wa_e = 1;
            expect_out("branch_e_stall", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        end
        tick(); branch_d = 1; pcsrc_d = 1; rs_d = 1; rt_d = 2; we_e = 1; wa_e = 0;
        expect_out("branch_e_release", ex(0, 1, 0, 0, 2'b00, 2'b00, 0));
        tick(); branch_d = 1; memtoreg_m = 1; we_m = 1; wa_m = 2; rs_d = 1; rt_d = 2;
        expect_out("branch_m_load_stall", ex(1, 0, 0, 1, 2'b00, 2'b00, 0));

        tick(); md_start_e = 1; md_use_d = 1;
        expect_out("md_start_stall", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            tick(); md_use_d = 1;
            expect_out("md_busy_stall", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
        end
        tick(); md_use_d = 1;
        expect_out("md_release", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); md_start_e = 1; md_use_d = 1;
        expect_out("md_restart_a", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); md_use_d = 1;
        expect_out("md_restart_b", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
        tick(); md_start_e = 1; md_use_d = 1;
        expect_out("md_restart_busy", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
        for (int i = 0; i < 3; i++) begin
            tick(); md_use_d = 1;
            expect_out("md_restart_hold", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
        end
        tick(); md_use_d = 1;
        expect_out("md_restart_release", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); md_start_e = 1;
        expect_out("md_start_no_use", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("md_busy_no_use", ex(0, 0, 0, 0, 2'b00, 2'b00, 1));
        end
        tick();
        expect_out("md_idle", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); md_start_e = 1; md_use_d = 1;
        expect_out("md_rst_start", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); md_use_d = 1;
        expect_out("md_rst_busy", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
        tick(); md_use_d = 1; rst = 1'b1;
        expect_out("md_async_rst", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); md_use_d = 1; rst = 1'b0;
        expect_out("md_after_rst", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        tick(); memtoreg_e = 1; we_e = 1; wa_e = 4; rt_d = 4;
        expect_out("perf_load_use", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));
        tick(); pcsrc_d = 1;
        expect_out("perf_jump", ex(0, 1, 0, 0, 2'b00, 2'b00, 0));
        tick();
        expect_out("final_idle", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (perf_stall !== 32'(exp_stall_cnt)) begin
            errors++;
            $display("FAIL perf_stall: got %0d expected %0d", perf_stall, exp_stall_cnt);
        end
        checks++;
        if (perf_flush !== 32'(exp_flush_cnt)) begin
            errors++;
            $display("FAIL perf_flush: got %0d expected %0d", perf_flush, exp_flush_cnt);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
